// File: rtl/slink_tx_align_pkg.sv
// rtl/slink_tx_align_pkg.sv - shared state encoding and sync-word constants for the S-Link TX aligner.
package slink_tx_align_pkg;

  typedef enum logic [1:0] {
    OFF      = 2'd0,
    WAIT_RDY = 2'd1,
    TRAIN    = 2'd2,
    ACTIVE   = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE  = 8'hBC;
  localparam logic [7:0] FILL_BYTE  = 8'h55;
  localparam int         MAX_WORD_W = 256;

  // Lowest byte is the comma-like marker, the remaining bytes of the lane are filler.
  function automatic logic [MAX_WORD_W-1:0] sync_word(input int dw);
    logic [MAX_WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_WORD_W / 8; i++) begin
      if (i < dw / 8) begin
        w[i*8 +: 8] = (i == 0) ? SYNC_BYTE : FILL_BYTE;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/slink_sync_2ff.sv
// rtl/slink_sync_2ff.sv - two-flop synchronizer bringing phy_tx_ready into the txclk domain.
module slink_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/slink_tx_align_gen.sv
// rtl/slink_tx_align_gen.sv - S-Link TX training generator: sync burst after PHY ready, then link data pass-through.
// Optional periodic sync insertion in ACTIVE is enabled by defining SLINK_TX_ALIGN_PERIODIC_EN.
module slink_tx_align_gen
  import slink_tx_align_pkg::*;
#(
  parameter int         DATA_WIDTH   = 8,
  parameter int         NUM_LANES    = 4,
  parameter int         TRAIN_CYCLES = 64,
  parameter logic [7:0] IDLE_BYTE    = 8'h00,
  parameter int         SYNC_PERIOD  = 1024
) (
  input  logic                            txclk,
  input  logic                            tx_reset,
  input  logic                            enable,
  input  logic                            phy_tx_ready,
  input  logic                            train_req,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] link_data,
  input  logic                            link_valid,
  output logic                            link_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] tx_data,
  output logic                            training,
  output logic                            active
);

  localparam int WORD_W = NUM_LANES * DATA_WIDTH;
  localparam int CNT_W  = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;

  localparam logic [CNT_W-1:0]      TRAIN_LOAD = CNT_W'(TRAIN_CYCLES - 1);
  localparam logic [MAX_WORD_W-1:0] SYNC_FULL  = sync_word(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] SYNC_LANE  = SYNC_FULL[DATA_WIDTH-1:0];
  localparam logic [WORD_W-1:0]     SYNC_WORD  = {NUM_LANES{SYNC_LANE}};
  localparam logic [WORD_W-1:0]     IDLE_WORD  = {(WORD_W / 8){IDLE_BYTE}};

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8 || DATA_WIDTH > MAX_WORD_W ||
      NUM_LANES < 1 || TRAIN_CYCLES < 1 || SYNC_PERIOD < 1) begin : g_bad_params
    $error("slink_tx_align_gen: unsupported parameter set");
  end

  state_t             state, state_d;
  logic [CNT_W-1:0]   train_cnt, train_cnt_d;
  logic [WORD_W-1:0]  tx_data_d;
  logic               rdy_s;
  logic               sync_slot;
  logic               xfer;

  slink_sync_2ff u_rdy_sync (
    .clk (txclk),
    .rst (tx_reset),
    .d   (phy_tx_ready),
    .q   (rdy_s)
  );

`ifdef SLINK_TX_ALIGN_PERIODIC_EN
  localparam int               PER_W    = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SYNC_PERIOD - 1);

  logic [PER_W-1:0] period_cnt, period_cnt_d;

  assign sync_slot = (state == ACTIVE) && (period_cnt == PER_LAST);

  always_ff @(posedge txclk or posedge tx_reset) begin
    if (tx_reset) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt_d;
    end
  end
`else
  assign sync_slot = 1'b0;
`endif

  // Ready is withheld whenever the word would not make it onto the wire next cycle.
  assign link_ready = (state == ACTIVE) && enable && rdy_s && !train_req && !sync_slot;
  assign xfer       = link_valid && link_ready;
  assign training   = (state == TRAIN);
  assign active     = (state == ACTIVE);

  always_comb begin
    state_d     = state;
    train_cnt_d = train_cnt;
`ifdef SLINK_TX_ALIGN_PERIODIC_EN
    period_cnt_d = '0;
`endif
    if (!enable) begin
      state_d = OFF;
    end else if ((state == TRAIN || state == ACTIVE) && !rdy_s) begin
      state_d = WAIT_RDY;
    end else begin
      case (state)
        OFF: begin
          state_d = WAIT_RDY;
        end
        WAIT_RDY: begin
          if (rdy_s) begin
            state_d     = TRAIN;
            train_cnt_d = TRAIN_LOAD;
          end
        end
        TRAIN: begin
          if (train_cnt != '0) begin
            train_cnt_d = train_cnt - CNT_W'(1);
          end else if (!train_req) begin
            state_d = ACTIVE;
          end
        end
        ACTIVE: begin
          if (train_req) begin
            state_d     = TRAIN;
            train_cnt_d = TRAIN_LOAD;
          end else begin
`ifdef SLINK_TX_ALIGN_PERIODIC_EN
            period_cnt_d = sync_slot ? '0 : period_cnt + PER_W'(1);
`endif
          end
        end
        default: begin
          state_d = OFF;
        end
      endcase
    end
  end

  // tx_data follows the state being entered, so it is always aligned with the registered state.
  always_comb begin
    tx_data_d = '0;
    if (state_d == TRAIN) begin
      tx_data_d = SYNC_WORD;
    end else if (state_d == ACTIVE) begin
      if (xfer) begin
        tx_data_d = link_data;
      end else if (sync_slot) begin
        tx_data_d = SYNC_WORD;
      end else begin
        tx_data_d = IDLE_WORD;
      end
    end
  end

  always_ff @(posedge txclk or posedge tx_reset) begin
    if (tx_reset) begin
      state     <= OFF;
      train_cnt <= '0;
      tx_data   <= '0;
    end else begin
      state     <= state_d;
      train_cnt <= train_cnt_d;
      tx_data   <= tx_data_d;
    end
  end

endmodule
